ex_weight_fetch: RTL

//  Read-side sequencer for the 1x1 expand-weight memory (Memory_1x1_EX_bneck). On start,

---
 rtl/ex_weight_fetch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ex_weight_fetch.sv
// Read sequencer for the 1x1 expand-weight memory: issues row reads from a base index
// and streams each weight row to the PE array through a small credited output FIFO.
module ex_weight_fetch #(
  parameter int Data_Width  = 14,
  parameter int Num_Files   = 16,
  parameter int Row_Length  = 16,
  parameter int Total_Width = Num_Files * Row_Length * Data_Width,
  parameter int height      = 657,
  parameter int Rd_Latency  = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [9:0]             i_base_index,
  input  logic [9:0]             i_num_rows,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_mem_en,
  output logic                   o_mem_rd,
  output logic                   o_mem_wr,
  output logic [9:0]             o_mem_index,
  input  logic [Total_Width-1:0] i_mem_data,
  output logic                   o_w_valid,
  input  logic                   i_w_ready,
  output logic [Total_Width-1:0] o_w_data,
  output logic                   o_w_last,
  output logic [1:0]             o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic [1:0]             r_state;
  logic [9:0]             r_base;
  logic [9:0]             r_num;
  logic [9:0]             r_issued;
  logic [9:0]             r_popped;
  logic                   r_done;
  logic                   r_err;
  logic [Rd_Latency-1:0]  r_rd_pipe;
  logic [Total_Width-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_rd;
  logic [CW:0]            w_inflight;
  logic [CW:0]            w_occ;
  logic [10:0]            w_end;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    f_next = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a row transfers on every cycle where o_w_valid & i_w_ready; while
  // o_w_valid is high and i_w_ready low, o_w_data and o_w_last hold their values.
  assign o_w_valid   = (r_count != '0);
  assign o_w_data    = r_fifo[r_rd_ptr];
  assign o_w_last    = o_w_valid & (r_popped == r_num - 10'd1);
  assign w_pop       = o_w_valid & i_w_ready;
  assign w_push      = r_rd_pipe[Rd_Latency-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < Rd_Latency; i++) begin
      w_inflight = w_inflight + {{CW{1'b0}}, r_rd_pipe[i]};
    end
  end

  // Reads in flight plus rows held (net of a pop this cycle) bound the FIFO fill.
  assign w_occ       = w_inflight + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
  assign w_rd        = (r_state == S_FETCH) && (w_occ < DEPTH_V);
  assign w_end       = {1'b0, r_base} + {1'b0, r_num};

  assign o_mem_rd    = w_rd;
  assign o_mem_en    = w_rd;
  assign o_mem_wr    = 1'b0;
  assign o_mem_index = r_base + r_issued;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_state     = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_popped  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_pipe <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      r_rd_pipe[0] <= w_rd;
      for (int i = 1; i < Rd_Latency; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end

      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_mem_data;
        r_wr_ptr         <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
        r_popped <= r_popped + 10'd1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base   <= i_base_index;
            r_num    <= i_num_rows;
            r_issued <= '0;
            r_popped <= '0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_end > 11'(height)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_num == 10'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_rd) begin
            r_issued <= r_issued + 10'd1;
            if (r_issued == r_num - 10'd1) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && o_w_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
